fifo_sync_flags: RTL and testbench
==================================

// Module: fifo_sync_flags
// PURPOSE
//  Parametrised single-clock FIFO, successor to the basic 16x8 FIFO.
//  Adds: fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow
//  error flags and a selectable first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks on one clock domain; drop-in for the basic FIFO when FWFT=0.
// PARAMETERS
//  DATA_WIDTH     8             word width in bits
//  DEPTH          16            number of entries; power of two, >=2
//  ADDR_WIDTH     $clog2(DEPTH) storage index width; derived, do not override
//  FWFT           0             0 = registered read (1-cycle latency); 1 = first-word-fall-through
//  AFULL_THRESH   DEPTH-2       o_almost_full asserted when count >= AFULL_THRESH
//  AEMPTY_THRESH  2             o_almost_empty asserted when count <= AEMPTY_THRESH
// PORTS
//  i_clk           in   1             clock, all logic on rising edge
//  i_rst           in   1             synchronous, active-high reset
//  i_wr_en         in   1             write request
//  i_wr_data       in   DATA_WIDTH    write data
//  i_rd_en         in   1             read request (FWFT=1: pop/acknowledge head word)
//  i_clr_err       in   1             clears o_overflow/o_underflow
//  o_rd_data       out  DATA_WIDTH    read data
//  o_rd_valid      out  1             o_rd_data holds a valid word
//  o_full          out  1             count == DEPTH
//  o_empty         out  1             count == 0
//  o_almost_full   out  1             count >= AFULL_THRESH
//  o_almost_empty  out  1             count <= AEMPTY_THRESH
//  o_count         out  ADDR_WIDTH+1  number of stored words, 0..DEPTH
//  o_overflow      out  1             sticky: write attempted while full
//  o_underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): pointers=0, o_count=0, o_empty=1, o_full=0, o_almost_empty=1,
//    o_almost_full=0, o_rd_data=0, o_rd_valid=0, o_overflow=0, o_underflow=0. Storage not cleared.
//    Reset mid-operation discards all contents; FIFO reads empty the cycle after.
//  - wr/rd pointers ADDR_WIDTH+1 bits, natural wrap; storage indexed by low ADDR_WIDTH bits.
//  - Accepted write = i_wr_en & !o_full; accepted read = i_rd_en & !o_empty (registered flags).
//  - Rejected write leaves storage and pointers untouched; rejected read leaves o_rd_data unchanged.
//  - Simultaneous rd+wr: when full -> read only, count-1; when empty -> write only, count+1;
//    otherwise both, count unchanged.
//  - o_count and all four level flags are registered; they reflect accepted ops at the same edge
//    that moves the pointers (write into empty -> o_empty=0 one cycle after the write edge).
//  - FWFT=0: o_rd_data registered from storage on accepted read, valid the cycle after;
//    o_rd_valid is a 1-cycle pulse per accepted read; o_rd_data holds between reads.
//  - FWFT=1: o_rd_data = storage[rd_ptr] combinationally; o_rd_valid = !o_empty;
//    accepted read advances to next word, visible the following cycle.
//  - o_overflow sets on i_wr_en & o_full; o_underflow sets on i_rd_en & o_empty; both hold until
//    i_clr_err; set wins over clear in the same cycle.
//  - Thresholds outside 0..DEPTH are a configuration error (elaboration-time assertion).
// TESTING
//  1. Reset 5 cycles, release -> o_empty=1, o_count=0, o_almost_empty=1, o_full=0, errors 0.
//  2. FWFT=0: write A5,3C,7E then rd_en 3 cycles -> o_rd_data A5,3C,7E each one cycle after its
//     rd_en, o_rd_valid high 3 cycles, o_empty=1 after last read.
//  3. Write 0x00..0x0F -> o_almost_full rises at count 14, o_full=1 at 16; write FF while full ->
//     o_overflow=1, o_count stays 16; drain 16 -> 00..0F in order, FF never appears.
//  4. Prefill 8, then rd_en=wr_en=1 for 20 cycles (pointer wrap) -> o_count stays 8, data order
//     preserved across wrap.
//  5. rd_en on empty -> o_underflow=1, o_rd_valid=0, o_count=0; pulse i_clr_err -> 0 next cycle;
//     i_clr_err with rd_en on empty same cycle -> o_underflow stays 1.
//  6. FWFT=1: write 42 -> next cycle o_empty=0, o_rd_valid=1, o_rd_data=42 with no rd_en; rd_en ->
//     o_empty=1 next cycle. Fill to 5, assert i_rst 1 cycle -> o_count=0, o_empty=1.

Source files
------------

// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with fill count, level flags, sticky errors and optional FWFT read
module fifo_sync_flags #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic                  o_almost_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_flags: DEPTH must be a power of two >= 2");
    end
    if (AFULL_THRESH < 0 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH) begin : g_bad_thresh
        $error("fifo_sync_flags: thresholds must lie in 0..DEPTH");
    end

    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] FULL_LVL   = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a simultaneous rd+wr on full/empty degrades to one op
    always_comb begin
        wr_acc     = i_wr_en & ~o_full;
        rd_acc     = i_rd_en & ~o_empty;
        count_next = o_count + (ADDR_WIDTH + 1)'(wr_acc) - (ADDR_WIDTH + 1)'(rd_acc);
    end

    always_ff @(posedge i_clk) begin
        if (wr_acc && !i_rst) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_count        <= '0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            o_count        <= count_next;
            o_full         <= (count_next == FULL_LVL);
            o_empty        <= (count_next == '0);
            o_almost_full  <= (count_next >= AFULL_LVL);
            o_almost_empty <= (count_next <= AEMPTY_LVL);
            // Set has priority over clear so an error in the clearing cycle is not lost
            o_overflow     <= (i_wr_en & o_full)  | (o_overflow  & ~i_clr_err);
            o_underflow    <= (i_rd_en & o_empty) | (o_underflow & ~i_clr_err);
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign o_rd_data  = mem[rd_ptr[ADDR_WIDTH-1:0]];
        assign o_rd_valid = ~o_empty;
    end else begin : g_reg_read
        logic [DATA_WIDTH-1:0] rd_data_q;
        logic                  rd_valid_q;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end

        assign o_rd_data  = rd_data_q;
        assign o_rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - scoreboard bench for fifo_sync_flags in registered and FWFT read modes
module tb_fifo_sync_flags;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, wr0, rd0, clr0;
    logic [7:0] wd0;
    logic [7:0] d0;
    logic       v0, f0, e0, af0, ae0, ov0, un0;
    logic [4:0] c0;

    logic       rst1, wr1, rd1, clr1;
    logic [7:0] wd1;
    logic [7:0] d1;
    logic       v1, f1, e1, af1, ae1, ov1, un1;
    logic [4:0] c1;

    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_reg (
        .i_clk(clk), .i_rst(rst0), .i_wr_en(wr0), .i_wr_data(wd0), .i_rd_en(rd0),
        .i_clr_err(clr0), .o_rd_data(d0), .o_rd_valid(v0), .o_full(f0), .o_empty(e0),
        .o_almost_full(af0), .o_almost_empty(ae0), .o_count(c0),
        .o_overflow(ov0), .o_underflow(un0)
    );

    fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst(rst1), .i_wr_en(wr1), .i_wr_data(wd1), .i_rd_en(rd1),
        .i_clr_err(clr1), .o_rd_data(d1), .o_rd_valid(v1), .o_full(f1), .o_empty(e1),
        .o_almost_full(af1), .o_almost_empty(ae1), .o_count(c1),
        .o_overflow(ov1), .o_underflow(un1)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] exp0;
    bit         acc_rd0;

    // Model pushes/pops happen when stimulus is driven; checks run #1 after the edge
    task automatic drive0(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        int sz = q0.size();
        wr0 = wr; wd0 = d; rd0 = rd; clr0 = clr;
        acc_rd0 = rd && (sz != 0);
        if (acc_rd0) exp0 = q0.pop_front();
        if (wr && sz != 16) q0.push_back(d);
        @(posedge clk); #1;
        wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0;
    endtask

    task automatic drive1(input logic wr, input logic [7:0] d, input logic rd);
        int sz = q1.size();
        wr1 = wr; wd1 = d; rd1 = rd;
        if (rd && sz != 0) void'(q1.pop_front());
        if (wr && sz != 16) q1.push_back(d);
        @(posedge clk); #1;
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        q0.delete(); q1.delete();
        n_cmp++; if (e0 !== 1'b1)  begin n_bad++; $display("FAIL reset_empty got %b want 1", e0); end
        n_cmp++; if (c0 !== 5'd0)  begin n_bad++; $display("FAIL reset_count got %0d want 0", c0); end
        n_cmp++; if (ae0 !== 1'b1) begin n_bad++; $display("FAIL reset_aempty got %b want 1", ae0); end
        n_cmp++; if (f0 !== 1'b0 || af0 !== 1'b0) begin n_bad++; $display("FAIL reset_full got %b%b want 00", f0, af0); end
        n_cmp++; if (ov0 !== 1'b0 || un0 !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b%b want 00", ov0, un0); end
        n_cmp++; if (d0 !== 8'h00 || v0 !== 1'b0) begin n_bad++; $display("FAIL reset_rd got %h/%b want 00/0", d0, v0); end
        n_cmp++; if (e1 !== 1'b1 || v1 !== 1'b0 || c1 !== 5'd0) begin n_bad++; $display("FAIL reset_fwft got e%b v%b c%0d want e1 v0 c0", e1, v1, c1); end
    endtask

    task automatic test_basic();
        logic [7:0] vals [3] = '{8'hA5, 8'h3C, 8'h7E};
        for (int i = 0; i < 3; i++) begin
            drive0(1'b1, vals[i], 1'b0, 1'b0);
            n_cmp++; if (ae0 !== (q0.size() <= 2)) begin n_bad++; $display("FAIL basic_aempty got %b at count %0d", ae0, q0.size()); end
        end
        for (int i = 0; i < 3; i++) begin
            drive0(1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++; if (v0 !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", v0); end
            n_cmp++; if (d0 !== exp0 || d0 !== vals[i]) begin n_bad++; $display("FAIL basic_data got %h want %h", d0, vals[i]); end
        end
        n_cmp++; if (e0 !== 1'b1) begin n_bad++; $display("FAIL basic_empty got %b want 1", e0); end
        drive0(1'b0, 8'h00, 1'b0, 1'b0);
        n_cmp++; if (v0 !== 1'b0 || d0 !== 8'h7E) begin n_bad++; $display("FAIL basic_hold got %h/%b want 7e/0", d0, v0); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            drive0(1'b1, 8'(i), 1'b0, 1'b0);
            n_cmp++; if (af0 !== (i + 1 >= 14)) begin n_bad++; $display("FAIL full_afull got %b at count %0d", af0, i + 1); end
            n_cmp++; if (c0 !== 5'(i + 1)) begin n_bad++; $display("FAIL full_count got %0d want %0d", c0, i + 1); end
        end
        n_cmp++; if (f0 !== 1'b1) begin n_bad++; $display("FAIL full_flag got %b want 1", f0); end
        drive0(1'b1, 8'hFF, 1'b0, 1'b0);
        n_cmp++; if (ov0 !== 1'b1 || c0 !== 5'd16) begin n_bad++; $display("FAIL full_overflow got ov%b c%0d want ov1 c16", ov0, c0); end
        drive0(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (ov0 !== 1'b0) begin n_bad++; $display("FAIL full_clr got %b want 0", ov0); end
        for (int i = 0; i < 16; i++) begin
            drive0(1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++; if (v0 !== 1'b1 || d0 !== exp0 || d0 !== 8'(i)) begin n_bad++; $display("FAIL full_drain got %h/%b want %h/1", d0, v0, 8'(i)); end
        end
        n_cmp++; if (e0 !== 1'b1 || c0 !== 5'd0) begin n_bad++; $display("FAIL full_drained got e%b c%0d want e1 c0", e0, c0); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 8; i++) drive0(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive0(1'b1, 8'h90 + 8'(i), 1'b1, 1'b0);
            n_cmp++; if (c0 !== 5'd8) begin n_bad++; $display("FAIL wrap_count got %0d want 8", c0); end
            n_cmp++; if (v0 !== 1'b1 || d0 !== exp0) begin n_bad++; $display("FAIL wrap_data got %h/%b want %h/1", d0, v0, exp0); end
        end
        for (int i = 0; i < 8; i++) begin
            drive0(1'b0, 8'h00, 1'b1, 1'b0);
            n_cmp++; if (d0 !== exp0 || d0 !== 8'h9C + 8'(i)) begin n_bad++; $display("FAIL wrap_drain got %h want %h", d0, 8'h9C + 8'(i)); end
        end
    endtask

    task automatic test_underflow();
        drive0(1'b0, 8'h00, 1'b1, 1'b0);
        n_cmp++; if (un0 !== 1'b1 || v0 !== 1'b0 || c0 !== 5'd0) begin n_bad++; $display("FAIL under_set got u%b v%b c%0d want u1 v0 c0", un0, v0, c0); end
        drive0(1'b0, 8'h00, 1'b0, 1'b1);
        n_cmp++; if (un0 !== 1'b0) begin n_bad++; $display("FAIL under_clr got %b want 0", un0); end
        drive0(1'b0, 8'h00, 1'b1, 1'b1);
        n_cmp++; if (un0 !== 1'b1) begin n_bad++; $display("FAIL under_set_wins got %b want 1", un0); end
        drive0(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_fwft();
        drive1(1'b1, 8'h42, 1'b0);
        n_cmp++; if (e1 !== 1'b0 || v1 !== 1'b1 || d1 !== 8'h42) begin n_bad++; $display("FAIL fwft_head got e%b v%b d%h want e0 v1 d42", e1, v1, d1); end
        drive1(1'b0, 8'h00, 1'b1);
        n_cmp++; if (e1 !== 1'b1 || v1 !== 1'b0) begin n_bad++; $display("FAIL fwft_pop got e%b v%b want e1 v0", e1, v1); end
        for (int i = 0; i < 5; i++) begin
            drive1(1'b1, 8'h50 + 8'(i), 1'b0);
            n_cmp++; if (d1 !== q1[0] || c1 !== 5'(q1.size())) begin n_bad++; $display("FAIL fwft_fill got d%h c%0d want d%h c%0d", d1, c1, q1[0], q1.size()); end
        end
        drive1(1'b0, 8'h00, 1'b1);
        n_cmp++; if (d1 !== q1[0] || d1 !== 8'h51) begin n_bad++; $display("FAIL fwft_next got %h want 51", d1); end
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        q1.delete();
        n_cmp++; if (c1 !== 5'd0 || e1 !== 1'b1 || v1 !== 1'b0) begin n_bad++; $display("FAIL fwft_reset got c%0d e%b v%b want c0 e1 v0", c1, e1, v1); end
    endtask

    initial begin
        rst0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; wd0 = 8'h00;
        rst1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; wd1 = 8'h00;
        exp0 = 8'h00; acc_rd0 = 1'b0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_underflow();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
